// File: rtl/stack_unit_if.sv
// Command/status bundle between the control unit (master) and the operand stack (slave).
// Commands are consumed every cycle; status outputs are registered-state only.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clear;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic             tos_zero;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, din, err_clear,
    input  tos, nos, tos_zero, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din, err_clear,
    output tos, nos, tos_zero, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// Operand stack for the stack CPU; sticky overflow/underflow flags exist only with STACK_GUARD_EN.
// Latency: push/pop/replace take effect on the next rising edge; outputs depend on state only.
// Backpressure: none; refused commands are dropped and reported through the flags.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  stack_unit_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    sp_m1, sp_m2;
  logic             is_empty, is_full;

  assign sp_m1    = sp_q - CW'(1);
  assign sp_m2    = sp_q - CW'(2);
  assign is_empty = (sp_q == '0);
  assign is_full  = (sp_q == CW'(DEPTH));

  always_comb begin
    mem_d = mem_q;
    sp_d  = sp_q;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (!is_full) begin
          mem_d[sp_q[AW-1:0]] = bus.din;
          sp_d                = sp_q + CW'(1);
        end
      end
      2'b01: begin
        if (!is_empty) sp_d = sp_m1;
      end
      2'b11: begin
        // Replace-top; on an empty stack this degrades to a plain push.
        if (!is_empty) begin
          mem_d[sp_m1[AW-1:0]] = bus.din;
        end else begin
          mem_d[0] = bus.din;
          sp_d     = CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q  <= sp_d;
      mem_q <= mem_d;
    end
  end

  assign bus.tos      = is_empty ? '0 : mem_q[sp_m1[AW-1:0]];
  assign bus.nos      = (sp_q < CW'(2)) ? '0 : mem_q[sp_m2[AW-1:0]];
  assign bus.tos_zero = (bus.tos == '0);
  assign bus.count    = sp_q;
  assign bus.empty    = is_empty;
  assign bus.full     = is_full;

`ifdef STACK_GUARD_EN
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic ovf_set, unf_set;

  assign ovf_set = bus.push & ~bus.pop & is_full;
  assign unf_set = bus.pop & is_empty;

  // A new error in the same cycle as err_clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_set | (ovf_q & ~bus.err_clear);
    unf_d = unf_set | (unf_q & ~bus.err_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  logic unused_err_clear;
  assign unused_err_clear = bus.err_clear;
  assign bus.overflow     = 1'b0;
  assign bus.underflow    = 1'b0;
`endif
endmodule

// File: tb/tb_stack_unit.sv
// Directed table-driven bench for stack_unit at DEPTH=4, WIDTH=8, plus hand sequences for timing corners.
module tb_stack_unit;
`ifdef STACK_GUARD_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stack_unit_if #(.WIDTH(8), .DEPTH(4)) bus ();
  stack_unit #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    bit         rst, psh, pp, clr;
    logic [7:0] din, cnt, tos, nos;
    bit         ovf, unf;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(bit rst, bit psh, bit pp, logic [7:0] din, bit clr,
                              logic [7:0] cnt, logic [7:0] tos, logic [7:0] nos,
                              bit ovf, bit unf);
    vec_t v;
    v.rst = rst; v.psh = psh; v.pp = pp; v.din = din; v.clr = clr;
    v.cnt = cnt; v.tos = tos; v.nos = nos; v.ovf = ovf & G; v.unf = unf & G;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit psh, input bit pp, input logic [7:0] din,
                       input bit clr);
    reset = rst; bus.push = psh; bus.pop = pp; bus.din = din; bus.err_clear = clr;
  endtask

  task automatic check_all(input string tag, input logic [7:0] cnt, input logic [7:0] tos,
                           input logic [7:0] nos, input bit ovf, input bit unf);
    chk({tag, ".count"},     8'(bus.count), cnt);
    chk({tag, ".tos"},       bus.tos, tos);
    chk({tag, ".nos"},       bus.nos, nos);
    chk({tag, ".tos_zero"},  8'(bus.tos_zero), 8'(tos == 8'h00));
    chk({tag, ".empty"},     8'(bus.empty), 8'(cnt == 8'd0));
    chk({tag, ".full"},      8'(bus.full), 8'(cnt == 8'd4));
    chk({tag, ".overflow"},  8'(bus.overflow), 8'(ovf));
    chk({tag, ".underflow"}, 8'(bus.underflow), 8'(unf));
  endtask

  initial begin
    //                rst psh pop din    clr  cnt  tos    nos    ovf unf
    vecs.push_back(mk(1, 1, 0, 8'h55, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h11, 0, 1, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h22, 0, 2, 8'h22, 8'h11, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h33, 0, 3, 8'h33, 8'h22, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 2, 8'h22, 8'h11, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 1, 8'h11, 8'h00, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h01, 0, 1, 8'h01, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h02, 0, 2, 8'h02, 8'h01, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h03, 0, 3, 8'h03, 8'h02, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h04, 0, 4, 8'h04, 8'h03, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h99, 0, 4, 8'h04, 8'h03, 1, 0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 4, 8'h04, 8'h03, 0, 0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 1, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h07, 0, 1, 8'h07, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h3C, 0, 2, 8'h3C, 8'h07, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h00, 0, 2, 8'h00, 8'h07, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'h5A, 0, 2, 8'h5A, 8'h07, 0, 0));
    vecs.push_back(mk(1, 1, 1, 8'h77, 0, 0, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 8'hA5, 0, 1, 8'hA5, 8'h00, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hB1, 0, 2, 8'hB1, 8'hA5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hB2, 0, 3, 8'hB2, 8'hB1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hB3, 0, 4, 8'hB3, 8'hB2, 0, 1));
    vecs.push_back(mk(0, 1, 1, 8'hC0, 0, 4, 8'hC0, 8'hB2, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'hFF, 1, 4, 8'hC0, 8'hB2, 1, 0));

    drive(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].psh, vecs[i].pp, vecs[i].din, vecs[i].clr);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].cnt, vecs[i].tos, vecs[i].nos,
                vecs[i].ovf, vecs[i].unf);
    end

    // Outputs must not react to inputs before the edge; tos is the popped value in the pop cycle.
    drive(1, 0, 0, 8'h00, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 8'h6E, 0);
    #1;
    chk("no_comb_path.tos", bus.tos, 8'h00);
    chk("no_comb_path.count", 8'(bus.count), 8'd0);
    @(posedge clk); #1;
    drive(0, 0, 1, 8'h00, 0);
    #1;
    chk("pop_cycle.tos", bus.tos, 8'h6E);
    chk("pop_cycle.tos_zero", 8'(bus.tos_zero), 8'd0);
    @(posedge clk); #1;
    check_all("after_pop", 0, 8'h00, 8'h00, 0, 0);

    // Reset mid-sequence wins over simultaneous commands.
    drive(0, 1, 0, 8'h12, 0);
    @(posedge clk); #1;
    drive(0, 1, 0, 8'h34, 0);
    @(posedge clk); #1;
    check_all("mid_seq", 2, 8'h34, 8'h12, 0, 0);
    drive(1, 1, 1, 8'h56, 1);
    @(posedge clk); #1;
    check_all("mid_reset", 0, 8'h00, 8'h00, 0, 0);

    // Entries are not cleared by reset but must stay hidden behind count.
    drive(0, 1, 0, 8'h80, 0);
    @(posedge clk); #1;
    check_all("post_reset_push", 1, 8'h80, 8'h00, 0, 0);

    drive(0, 0, 0, 8'h00, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack CPU. It sits directly downstream of the control unit: it consumes the control unit's `push`/`pop` strobes and the write-data selected by `stack_src` (ALU result or MDR). It returns top-of-stack data to the A/B operand registers and to memory write-data, and supplies `tos_zero` back to the control unit for `jz`. Storage is a register array with a stack pointer, plus optional guard and error logic.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 8, number of entries; power of two, ≥ 2.

- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high reset.
- `push` input 1: push `din` this cycle.
- `pop` input 1: remove top entry this cycle.
- `din` input WIDTH: data to push.
- `err_clear` input 1: clears sticky error flags.
- `tos` output WIDTH: current top entry; 0 when empty.
- `nos` output WIDTH: entry below top; 0 when count < 2.
- `tos_zero` output 1: `tos == 0`; 1 when empty.
- `count` output $clog2(DEPTH)+1: number of valid entries.
- `empty` output 1: count == 0.
- `full` output 1: count == DEPTH.
- `overflow` output 1: sticky; a push was refused on full.
- `underflow` output 1: sticky; a pop was refused on empty.

## Operation
- State:
  - `mem[0..DEPTH-1]`, entries never cleared.
  - `sp` = count, 0..DEPTH.
  - `overflow` and `underflow` registers.
- Reset (synchronous, priority over everything else):
  - sp=0 and flags=0.
  - Resulting outputs: `tos`=0, `nos`=0, `tos_zero`=1, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0.
- Command decode each rising edge:
  - Push only, not full: mem[sp] ← din; sp ← sp+1.
  - Push only, full: no storage change; overflow set (guard build).
  - Pop only, not empty: sp ← sp−1. Storage is untouched; the read value is `tos` in the same cycle before the edge.
  - Pop only, empty: no change; underflow set (guard build).
  - Push+pop, not empty: replace top. mem[sp−1] ← din; sp unchanged. Full and empty never flag in this case.
  - Push+pop, empty: performed as push only (sp ← 1). Underflow set (guard build).
  - Neither: hold.
- Outputs:
  - `tos` = mem[sp−1], `nos` = mem[sp−2], gated to 0 per the interface rules.
  - `tos`, `nos`, `tos_zero`, `empty`, `full` and `count` are combinational from registered state only; there is no path from inputs to outputs.
- Flags:
  - Sticky until reset or `err_clear`.
  - If `err_clear` and a new error occur in the same cycle, set wins.
- Arithmetic: sp never leaves 0..DEPTH. The index uses the low $clog2(DEPTH) bits.

## Timing
- Write and pop latency: 1 cycle. The effect is visible on outputs immediately after the edge.
- `tos` is valid in the same cycle as `pop`. The control unit's LOAD_A/LOAD_B capture `tos` on the edge at which the pop retires.
- Push at edge k, then pop at edge k+1 returns the pushed `din` (no bypass needed; the registered array is written at k).
- `tos_zero` updates combinationally after each edge. For `jz`, the control unit samples it in the JUMP state, one cycle after any push.
- Reset mid-sequence: the next edge with `reset`=1 empties the stack regardless of `push`/`pop`.
- No handshake: commands are always accepted in one cycle. Refusals are reported only via the flags.

## Configuration
- Macro: `STACK_GUARD_EN`.
- Defined:
  - Overflow and underflow detection as described above.
  - Refused operations leave storage and sp unchanged.
- Undefined:
  - Refused operations are still ignored; storage is always safe.
  - `overflow` and `underflow` are tied to 0, with no flag registers.
  - `err_clear` is unused.

## Test plan
All scenarios use DEPTH=4, WIDTH=8.
- Reset check: assert `reset` with `push`=1 and `din`=0x55 → `count`=0, `empty`=1, `tos`=0, `tos_zero`=1, flags 0.
- Push order: push 0x11, 0x22, 0x33 → `tos`=0x33, `nos`=0x22, `count`=3. Then pop twice → `tos`=0x11, `count`=1, `tos_zero`=0.
- Overflow: push 0x01..0x04, then push 0x99 → `full`=1, `tos`=0x04, `count`=4. `overflow`=1 with guard, 0 without. Then `err_clear` → `overflow`=0.
- Underflow: pop on empty → `count`=0, `tos`=0. `underflow`=1 with guard. Same-cycle `err_clear`+new underflow → flag stays 1.
- Replace: stack {0x07, 0x00}, push+pop with `din`=0x00 → `count`=2, `tos`=0x00, `tos_zero`=1, `nos`=0x07.
- Push+pop on empty with `din`=0xA5 → `count`=1, `tos`=0xA5; `underflow`=1 (guard build).
